i2c_master_ctrl: RTL and testbench

//  Single-byte I2C master sequencer: generates START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_clk_gen.sv | 39 +++
 rtl/i2c_master_ctrl.sv | 131 +++++++++++++
 tb/tb_i2c_master_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C master sequencer:
// transfer states, SCL quarter index and R/W bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        AACK,
        DATA,
        DACK,
        STOP
    } i2c_state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_clk_gen.sv
// SCL quarter-period generator: divider plus quarter index.
// hold freezes the divider while a slave stretches SCL.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     en,
    input  logic     hold,
    output logic     qtick,
    output quarter_t q
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign qtick = en && !hold && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            q   <= Q0;
        end else if (!en) begin
            cnt <= '0;
            q   <= Q0;
        end else if (!hold) begin
            if (qtick) begin
                cnt <= '0;
                q   <= quarter_t'(q + 2'd1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, one data byte, ACK, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rd_data,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    i2c_state_t state;
    quarter_t   q;
    logic       qtick;
    logic       hold;
    logic [2:0] bit_cnt;
    logic [7:0] shift_r;
    logic [7:0] wr_byte;
    logic       rw_r;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = (q == Q2) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    i2c_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (busy),
        .hold   (hold),
        .qtick  (qtick),
        .q      (q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift_r <= '0;
            wr_byte <= '0;
            rw_r    <= I2C_WR;
            busy    <= 1'b0;
            done    <= 1'b0;
            nack    <= 1'b0;
            rd_data <= '0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start_req && !busy) begin
                    shift_r <= {dev_addr, rw};
                    wr_byte <= wr_data;
                    rw_r    <= rw;
                    busy    <= 1'b1;
                    nack    <= 1'b0;
                    state   <= START;
                end
            end else if (qtick) begin
                unique case (state)
                    START: begin
                        if (q == Q1) sda_oe <= 1'b1;
                        if (q == Q3) begin
                            scl_oe  <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ADDR;
                        end
                    end
                    ADDR, DATA: begin
                        // read data bits leave SDA to the slave
                        if (q == Q0)
                            sda_oe <= (state == DATA && rw_r == I2C_RD) ?
                                      1'b0 : ~shift_r[7];
                        if (q == Q1) scl_oe <= 1'b0;
                        if (q == Q2) shift_r <= {shift_r[6:0], sda_i};
                        if (q == Q3) begin
                            scl_oe  <= 1'b1;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= (state == ADDR) ? AACK : DACK;
                                if (state == DATA && rw_r == I2C_RD)
                                    rd_data <= shift_r;
                            end
                        end
                    end
                    AACK, DACK: begin
                        if (q == Q0) sda_oe <= 1'b0;
                        if (q == Q1) scl_oe <= 1'b0;
                        if (q == Q2 && sda_i &&
                            (state == AACK || rw_r == I2C_WR))
                            nack <= 1'b1;
                        if (q == Q3) begin
                            scl_oe  <= 1'b1;
                            shift_r <= wr_byte;
                            state   <= (state == AACK && !nack) ? DATA : STOP;
                        end
                    end
                    STOP: begin
                        if (q == Q0) sda_oe <= 1'b1;
                        if (q == Q1) scl_oe <= 1'b0;
                        if (q == Q2) sda_oe <= 1'b0;
                        if (q == Q3) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave on the wired-AND bus,
// random transfers checked against protocol-level expectations.
module tb_i2c_master_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy, done, nack;
    logic [7:0] rd_data;
    logic       scl_oe, sda_oe;

    logic       scl_hold = 1'b0;
    logic       sda_slv = 1'b0;
    wire        scl_line = ~scl_oe & ~scl_hold;
    wire        sda_line = ~sda_oe & ~sda_slv;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] m_rd = '0;

    // slave configuration and observations
    logic       s_ack_addr = 1'b0;
    logic       s_ack_data = 1'b0;
    logic [7:0] s_rd_byte = '0;
    logic       stretch_arm = 1'b0;
    int         n = 0;
    int         starts = 0;
    int         stops = 0;
    logic       bits [0:39];

    i2c_master_ctrl #(
        .CLK_DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_req(start_req),
        .rw       (rw),
        .dev_addr (dev_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .nack     (nack),
        .rd_data  (rd_data),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .scl_i    (scl_line),
        .sda_i    (sda_line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    always @(negedge sda_line) if (scl_line === 1'b1) begin
        n = 0;
        starts++;
    end

    always @(posedge sda_line) if (scl_line === 1'b1) stops++;

    always @(posedge scl_line) begin
        if (n < 40) bits[n] = sda_line;
        n++;
    end

    // slave drives the bit for rising edge k while SCL is low
    always @(negedge scl_line) begin
        int k;
        k = n + 1;
        sda_slv = 1'b0;
        if (k == 9)
            sda_slv = s_ack_addr;
        else if (k >= 10 && k <= 17 && bits[7] === 1'b1 && s_ack_addr)
            sda_slv = ~s_rd_byte[17-k];
        else if (k == 18 && bits[7] === 1'b0 && s_ack_addr)
            sda_slv = s_ack_data;
        if (stretch_arm && n == 3) begin
            scl_hold    = 1'b1;
            stretch_arm = 1'b0;
        end
    end

    always @(negedge scl_oe) if (scl_hold) begin
        repeat (10) @(posedge clk);
        #1 scl_hold = 1'b0;
    end

    function automatic logic [7:0] sbyte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bits[base+i];
        return b;
    endfunction

    task automatic launch(input logic r, input logic [6:0] a,
                          input logic [7:0] d, input logic aa,
                          input logic ad, input logic [7:0] rb,
                          input bit now, output int c_acc);
        if (!now) @(negedge clk);
        s_ack_addr = aa;
        s_ack_data = ad;
        s_rd_byte  = rb;
        rw         = r;
        dev_addr   = a;
        wr_data    = d;
        start_req  = 1'b1;
        c_acc      = cyc + 1;
        @(posedge clk);
        #1;
        start_req = 1'b0;
        dev_addr  = 7'($urandom);
        wr_data   = 8'($urandom);
        rw        = 1'($urandom);
    endtask

    task automatic wait_done(input int c_acc, output int lat, output bit to);
        to  = 1'b1;
        lat = -1;
        for (int i = 0; i < 200 * DIV; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - c_acc;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({scl_oe, sda_oe, busy, done, nack, rd_data} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {scl_oe, sda_oe, busy, done, nack, rd_data});
        end
        checks++;
        if ({scl_line, sda_line} !== 2'b11) begin
            failures++;
            $display("FAIL reset_bus got=%b exp=11", {scl_line, sda_line});
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_rd = '0;
    endtask

    task automatic test_write();
        int c, lat, s0;
        bit to;
        s0 = stops;
        launch(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, c);
        wait_done(c, lat, to);
        checks++;
        if (to || lat < 80 * DIV - 2 || lat > 80 * DIV + 2) begin
            failures++;
            $display("FAIL wr_latency got=%0d exp=%0d", lat, 80 * DIV);
        end
        checks++;
        if (sbyte(0) !== 8'hA0) begin
            failures++;
            $display("FAIL wr_addr_bits got=%h exp=a0", sbyte(0));
        end
        checks++;
        if (sbyte(9) !== 8'hA5) begin
            failures++;
            $display("FAIL wr_data_bits got=%h exp=a5", sbyte(9));
        end
        checks++;
        if ({bits[8], bits[17], nack, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL wr_ack_status got=%b exp=0000",
                     {bits[8], bits[17], nack, busy});
        end
        checks++;
        if (rd_data !== m_rd || stops !== s0 + 1 || n !== 19) begin
            failures++;
            $display("FAIL wr_misc got=%h/%0d/%0d exp=%h/%0d/19",
                     rd_data, stops - s0, n, m_rd, 1);
        end
    endtask

    task automatic test_read();
        int c, lat;
        bit to;
        launch(1'b1, 7'h50, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b0, c);
        wait_done(c, lat, to);
        m_rd = 8'h3C;
        checks++;
        if (to || lat < 80 * DIV - 2 || lat > 80 * DIV + 2) begin
            failures++;
            $display("FAIL rd_latency got=%0d exp=%0d", lat, 80 * DIV);
        end
        checks++;
        if (rd_data !== 8'h3C) begin
            failures++;
            $display("FAIL rd_data got=%h exp=3c", rd_data);
        end
        checks++;
        if ({sbyte(0), bits[17], nack} !== {8'hA1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rd_addr_nack got=%h/%b/%b exp=a1/1/0",
                     sbyte(0), bits[17], nack);
        end
    endtask

    task automatic test_no_slave();
        int c, lat, s0;
        bit to;
        s0 = stops;
        launch(1'b0, 7'h27, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, c);
        wait_done(c, lat, to);
        checks++;
        if (to || lat < 44 * DIV - 2 || lat > 44 * DIV + 2) begin
            failures++;
            $display("FAIL noack_latency got=%0d exp=%0d", lat, 44 * DIV);
        end
        checks++;
        if (nack !== 1'b1 || sbyte(0) !== 8'h4E) begin
            failures++;
            $display("FAIL noack_nack got=%b/%h exp=1/4e", nack, sbyte(0));
        end
        checks++;
        if (n !== 10 || stops !== s0 + 1 || rd_data !== m_rd) begin
            failures++;
            $display("FAIL noack_bus got=%0d/%0d/%h exp=10/1/%h",
                     n, stops - s0, rd_data, m_rd);
        end
    endtask

    task automatic test_reset_mid();
        int c, lat, st0;
        bit to, hit;
        logic [7:0] rb;
        st0 = starts;
        hit = 1'b0;
        launch(1'b0, 7'($urandom), 8'($urandom), 1'b1, 1'b1, 8'h00, 1'b0, c);
        for (int i = 0; i < 200 * DIV; i++) begin
            @(negedge clk);
            if (starts != st0 && n >= 14) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_reach got=%0d exp=14", n);
        end
        #2 reset_n = 1'b0;
        sda_slv = 1'b0;
        #1;
        checks++;
        if ({scl_oe, sda_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=000",
                     {scl_oe, sda_oe, busy});
        end
        m_rd = '0;
        @(negedge clk);
        reset_n = 1'b1;
        rb = 8'($urandom);
        launch(1'b1, 7'h33, 8'h00, 1'b1, 1'b0, rb, 1'b0, c);
        wait_done(c, lat, to);
        m_rd = rb;
        checks++;
        if (to || lat < 80 * DIV - 2 || lat > 80 * DIV + 2 ||
            rd_data !== rb || nack !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_next got=%0d/%h/%b exp=%0d/%h/0",
                     lat, rd_data, nack, 80 * DIV, rb);
        end
    endtask

    task automatic test_busy_ignore();
        int c, lat, st0;
        bit to;
        launch(1'b0, 7'h12, 8'h34, 1'b1, 1'b1, 8'h00, 1'b0, c);
        repeat (20) @(negedge clk);
        rw        = 1'b1;
        dev_addr  = 7'h7F;
        wr_data   = 8'h00;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        wait_done(c, lat, to);
        st0 = starts;
        checks++;
        if (to || lat < 80 * DIV - 2 || lat > 80 * DIV + 2 ||
            sbyte(0) !== 8'h24 || sbyte(9) !== 8'h34) begin
            failures++;
            $display("FAIL busy_ign_xfer got=%0d/%h/%h exp=%0d/24/34",
                     lat, sbyte(0), sbyte(9), 80 * DIV);
        end
        repeat (12 * DIV) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || starts !== st0) begin
            failures++;
            $display("FAIL busy_ign_queued got=%b/%0d exp=0/0",
                     busy, starts - st0);
        end
    endtask

    task automatic test_back_to_back();
        int c, lat;
        bit to;
        logic [7:0] rb;
        rb = 8'($urandom);
        launch(1'b0, 7'h41, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, c);
        wait_done(c, lat, to);
        checks++;
        if (to || busy !== 1'b0 || sbyte(9) !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_first got=%b/%b/%h exp=0/0/c3",
                     to, busy, sbyte(9));
        end
        launch(1'b1, 7'h41, 8'h00, 1'b1, 1'b0, rb, 1'b1, c);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got=%b/%b exp=1/0", busy, done);
        end
        wait_done(c, lat, to);
        m_rd = rb;
        checks++;
        if (to || lat < 80 * DIV - 2 || lat > 80 * DIV + 2 ||
            rd_data !== rb || sbyte(0) !== 8'h83) begin
            failures++;
            $display("FAIL b2b_second got=%0d/%h/%h exp=%0d/%h/83",
                     lat, rd_data, sbyte(0), 80 * DIV, rb);
        end
    endtask

    task automatic test_random();
        int c, lat, s0, exp_lat, exp_n;
        bit to;
        logic r, aa, ad, exp_nack;
        logic [6:0] a;
        logic [7:0] d, rb, exp_data;
        for (int it = 0; it < 10; it++) begin
            r  = 1'($urandom);
            a  = 7'($urandom);
            d  = 8'($urandom);
            rb = 8'($urandom);
            aa = ($urandom_range(0, 3) != 0);
            ad = 1'($urandom);
            s0 = stops;
            launch(r, a, d, aa, ad, rb, 1'b0, c);
            wait_done(c, lat, to);
            exp_nack = !aa || (!r && !ad);
            exp_lat  = aa ? 80 * DIV : 44 * DIV;
            exp_n    = aa ? 19 : 10;
            exp_data = r ? rb : d;
            if (r && aa) m_rd = rb;
            checks++;
            if (to || lat < exp_lat - 2 || lat > exp_lat + 2) begin
                failures++;
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, exp_lat);
            end
            checks++;
            if (nack !== exp_nack || rd_data !== m_rd) begin
                failures++;
                $display("FAIL rnd%0d_status got=%b/%h exp=%b/%h",
                         it, nack, rd_data, exp_nack, m_rd);
            end
            checks++;
            if (sbyte(0) !== {a, r} || n !== exp_n || stops !== s0 + 1) begin
                failures++;
                $display("FAIL rnd%0d_bus got=%h/%0d/%0d exp=%h/%0d/1",
                         it, sbyte(0), n, stops - s0, {a, r}, exp_n);
            end
            if (aa) begin
                checks++;
                if (sbyte(9) !== exp_data) begin
                    failures++;
                    $display("FAIL rnd%0d_data got=%h exp=%h",
                             it, sbyte(9), exp_data);
                end
            end
        end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        int c, lat;
        bit to;
        stretch_arm = 1'b1;
        launch(1'b0, 7'h2B, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, c);
        wait_done(c, lat, to);
        checks++;
        if (to || lat < 80 * DIV + 8 || lat > 80 * DIV + 12 ||
            sbyte(0) !== 8'h56 || sbyte(9) !== 8'h96) begin
            failures++;
            $display("FAIL stretch got=%0d/%h/%h exp=%0d/56/96",
                     lat, sbyte(0), sbyte(9), 80 * DIV + 10);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_slave();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_random();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
